// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling FSM, valid/ack
// handshake with sticky framing and overrun flags.
module uart_rx #(
  parameter int word_size      = 8,
  parameter int size_bit_count = 3,
  parameter int clks_per_bit   = 16,
  parameter int cnt_width      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 rx_ack,
  output logic [word_size-1:0] data_bus,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 rx_busy
);

  // state   | meaning
  // IDLE    | line idle, waiting for a low rx_s
  // START   | timing to the middle of the start bit
  // DATA    | sampling word_size data bits, LSB first
  // STOP    | timing to the middle of the stop bit
  // BREAK   | stop bit was low, waiting for the line to return high
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [cnt_width-1:0]      HALF_M1  = cnt_width'(clks_per_bit / 2 - 1);
  localparam logic [cnt_width-1:0]      FULL_M1  = cnt_width'(clks_per_bit - 1);
  localparam logic [size_bit_count-1:0] LAST_BIT = size_bit_count'(word_size - 1);

  state_t                    state_q;
  logic [1:0]                sync_q;
  logic [cnt_width-1:0]      cnt_q;
  logic [size_bit_count-1:0] bit_q;
  logic [word_size-1:0]      shreg_q;
  logic [word_size-1:0]      data_q;
  logic                      valid_q;
  logic                      fe_q;
  logic                      oe_q;
  logic                      busy_q;
  logic                      rx_s;
  logic                      valid_d;

  assign rx_s = sync_q[1];
  // An ack on this edge frees the holding register before any stop-bit load.
  assign valid_d = valid_q & ~rx_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], serial_in};
      valid_q <= valid_d;
      fe_q    <= fe_q & ~rx_ack;
      oe_q    <= oe_q & ~rx_ack;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= ST_DATA;
              bit_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + cnt_width'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s, shreg_q[word_size-1:1]};
            if (bit_q == LAST_BIT) begin
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + size_bit_count'(1);
            end
          end else begin
            cnt_q <= cnt_q + cnt_width'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rx_s) begin
              if (valid_d) begin
                oe_q <= 1'b1;
              end else begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
              end
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              fe_q    <= 1'b1;
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + cnt_width'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_bus      = data_q;
  assign rx_valid      = valid_q;
  assign framing_error = fe_q;
  assign overrun_error = oe_q;
  assign rx_busy       = busy_q;

endmodule
